fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch stage with a prefetch queue.
- Issues sequential reads to instruction memory and buffers returned words in a DEPTH-entry FIFO.
- Delivers decoded-length packets to IF/ID over a valid/ready handshake: one word for normal instructions, two words (instruction + immediate) for I-type.
- Handles reset, exception, interrupt, popped-PC and jump redirects with fixed priority, flushing all buffered and in-flight words.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- INSTR_W, 16, instruction and immediate word width.
- DEPTH, 4, prefetch queue entries (power of 2, >=2).
- OPC_W, 4, opcode field width (MSBs of the instruction word).
- ITYPE_OPC, 8, opcode value marking a two-word I-type instruction.
- RESET_VEC, 32, PC loaded on reset.
- EXC_VEC, 32, PC loaded on exception.
- INT_VEC, 0, PC loaded on interrupt.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- exception  in  1  redirect to EXC_VEC; level, sampled each edge.
- interrupt  in  1  redirect to INT_VEC; sampled each edge.
- pop_pc  in  1  redirect to pop_value.
- pop_value  in  ADDR_W  popped PC.
- jmp  in  1  redirect to jmp_target.
- jmp_target  in  ADDR_W  jump target.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  read address.
- imem_rdata  in  INSTR_W  read data, one cycle after request.
- imem_rvalid  in  1  qualifies imem_rdata.
- out_valid  out  1  packet available.
- out_ready  in  1  IF/ID accepts packet (low = stall).
- out_instr  out  INSTR_W  instruction word.
- out_imm  out  INSTR_W  immediate word; 0 when not I-type.
- out_pc  out  ADDR_W  address following the packet (instr addr + 1 or + 2).
- out_int  out  1  first packet after an interrupt redirect.
- q_count  out  $clog2(DEPTH)+1  occupied queue entries.

Behaviour:
- Reset (async): fetch_pc = RESET_VEC; queue empty; in-flight count 0; epoch 0; int_pending 0. Outputs imem_req=0, out_valid=0, out_instr=0, out_imm=0, out_pc=0, out_int=0, q_count=0.
- Reset release: first imem_req on the first rising edge after release.
- Issue rule:
  - imem_req=1 when q_count + inflight < DEPTH and no redirect this cycle.
  - imem_addr = fetch_pc; fetch_pc increments by 1 per issued request, wrapping mod 2^ADDR_W.
- Response handling:
  - imem_rvalid pushes {imem_rdata, word_addr} into the queue only if the tag epoch matches the current epoch.
  - Stale responses are dropped and decrement inflight.
  - Queue can never overflow, because issue reserves a slot.
- Packet formation (combinational from queue head):
  - op = head[INSTR_W-1 -: OPC_W].
  - If op != ITYPE_OPC: out_valid = (q_count>=1).
  - If op == ITYPE_OPC: out_valid = (q_count>=2); out_imm = entry head+1.
  - The immediate word is never decoded as an opcode.
  - On out_valid & out_ready, pop 1 or 2 entries. Push and pop in the same cycle are allowed.
  - Outputs are held stable while out_valid & !out_ready.
- Redirect priority: exception > interrupt > pop_pc > jmp.
  - On any redirect edge: fetch_pc = target; queue cleared; epoch toggles; imem_req=0 that cycle.
  - The packet shown that cycle is NOT consumed, even if out_ready=1.
  - Lower-priority redirects in the same cycle are ignored.
- Interrupt: sets int_pending. The first packet delivered afterwards has out_int=1; int_pending clears on its handshake.
- Exception in the same cycle as interrupt: exception wins and int_pending is not set.
- Wrap: queue pointers wrap mod DEPTH.
- Reset mid-operation: immediate return to reset state. Outstanding memory responses arriving after reset are discarded (inflight cleared, epoch reset).

Test Plan:
1. Reset, then memory holding 0x1000,0x2000,0x3000 at 32..34 with out_ready=1 -> packets at 0x1000/pc 33, 0x2000/pc 34, 0x3000/pc 35; first imem_addr=32.
2. I-type 0x8123 at 40, imm 0xBEEF at 41 -> one packet: out_instr=0x8123, out_imm=0xBEEF, out_pc=42; 0xBEEF is never emitted as out_instr.
3. out_ready=0 for 10 cycles with DEPTH=4 -> q_count saturates at 4, imem_req=0, out_instr held constant; releasing out_ready resumes in order.
4. jmp=1, jmp_target=100 while 2 requests are in flight -> stale responses dropped; next packet comes from addr 100, out_pc=101.
5. exception and interrupt asserted in the same cycle -> fetch_pc=EXC_VEC(32); the next packet has out_int=0.
6. interrupt alone, then reset asserted mid-fetch -> INT_VEC packet has out_int=1; reset clears all outputs to 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Brief    : Instruction-fetch stage with a DEPTH-entry prefetch queue.
//            Issues sequential instruction-memory reads, buffers returned
//            words, and hands one- or two-word packets (instruction, plus
//            immediate for I-type) to IF/ID over valid/ready. Exception,
//            interrupt, popped-PC and jump redirects flush buffered and
//            in-flight words using an epoch tag.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int ADDR_W    = 32,
    parameter int INSTR_W   = 16,
    parameter int DEPTH     = 4,
    parameter int OPC_W     = 4,
    parameter int ITYPE_OPC = 8,
    parameter int RESET_VEC = 32,
    parameter int EXC_VEC   = 32,
    parameter int INT_VEC   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     exception,
    input  logic                     interrupt,
    input  logic                     pop_pc,
    input  logic [ADDR_W-1:0]        pop_value,
    input  logic                     jmp,
    input  logic [ADDR_W-1:0]        jmp_target,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    input  logic                     imem_rvalid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [INSTR_W-1:0]       out_imm,
    output logic [ADDR_W-1:0]        out_pc,
    output logic                     out_int,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [OPC_W-1:0]   c_ITYPE      = OPC_W'(ITYPE_OPC);
    localparam logic [ADDR_W-1:0]  c_RESET_VEC  = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0]  c_EXC_VEC    = ADDR_W'(EXC_VEC);
    localparam logic [ADDR_W-1:0]  c_INT_VEC    = ADDR_W'(INT_VEC);
    localparam logic [ADDR_W-1:0]  c_PC_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  c_PC_TWO     = ADDR_W'(2);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_TWO    = c_PTR_W'(2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_TWO    = c_CNT_W'(2);
    localparam logic [c_CNT_W:0]   c_DEPTH_WIDE = (c_CNT_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_epoch;
    logic               r_int_pending;

    // Prefetch queue: instruction word plus the address it was fetched from
    logic [INSTR_W-1:0] r_q_instr [DEPTH];
    logic [ADDR_W-1:0]  r_q_addr  [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_q_count;

    // In-flight tag FIFO: responses return in order, each carrying the
    // epoch and address recorded when the request was issued
    logic [ADDR_W-1:0]  r_tag_addr  [DEPTH];
    logic               r_tag_epoch [DEPTH];
    logic [c_PTR_W-1:0] r_tag_rd;
    logic [c_PTR_W-1:0] r_tag_wr;
    logic [c_CNT_W-1:0] r_inflight;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_redirect;
    logic [ADDR_W-1:0]  w_target;
    logic               w_set_int;
    logic [c_CNT_W:0]   w_occupied;
    logic               w_issue;
    logic               w_resp;
    logic               w_push;
    logic [ADDR_W-1:0]  w_resp_addr;
    logic [INSTR_W-1:0] w_head;
    logic [INSTR_W-1:0] w_next;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [OPC_W-1:0]   w_op;
    logic               w_itype;
    logic               w_valid;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_pop_cnt;
    logic [c_PTR_W-1:0] w_pop_ptr;

    // Redirect arbitration: exception > interrupt > pop_pc > jmp
    always_comb begin
        w_redirect = exception | interrupt | pop_pc | jmp;
        w_target   = r_fetch_pc;
        w_set_int  = 1'b0;
        if (exception) begin
            w_target = c_EXC_VEC;
        end else if (interrupt) begin
            w_target  = c_INT_VEC;
            w_set_int = 1'b1;
        end else if (pop_pc) begin
            w_target = pop_value;
        end else if (jmp) begin
            w_target = jmp_target;
        end
    end

    // Issue and response qualification; a slot is reserved at issue time
    // so queued plus in-flight words never exceed DEPTH
    always_comb begin
        w_occupied  = {1'b0, r_q_count} + {1'b0, r_inflight};
        w_issue     = ~reset & ~w_redirect & (w_occupied < c_DEPTH_WIDE);
        // A response with nothing outstanding belongs to a pre-reset request
        w_resp      = imem_rvalid & (r_inflight != '0);
        w_resp_addr = r_tag_addr[r_tag_rd];
        w_push      = w_resp & (r_tag_epoch[r_tag_rd] == r_epoch) & ~w_redirect;
    end

    // Packet formation from the queue head; the word after an I-type
    // opcode is only ever treated as its immediate
    always_comb begin
        w_head      = r_q_instr[r_rd_ptr];
        w_next      = r_q_instr[r_rd_ptr + c_PTR_ONE];
        w_head_addr = r_q_addr[r_rd_ptr];
        w_op        = w_head[INSTR_W-1 -: OPC_W];
        w_itype     = (w_op == c_ITYPE);
        w_valid     = w_itype ? (r_q_count >= c_CNT_TWO) : (r_q_count >= c_CNT_ONE);
        // The packet visible during a redirect is discarded, not consumed
        w_pop       = w_valid & out_ready & ~w_redirect;
        w_pop_cnt   = '0;
        w_pop_ptr   = '0;
        if (w_pop) begin
            w_pop_cnt = w_itype ? c_CNT_TWO : c_CNT_ONE;
            w_pop_ptr = w_itype ? c_PTR_TWO : c_PTR_ONE;
        end
    end

    // Output drive; data outputs read zero whenever no packet is offered
    always_comb begin
        imem_req  = w_issue;
        imem_addr = r_fetch_pc;
        out_valid = w_valid;
        out_instr = '0;
        out_imm   = '0;
        out_pc    = '0;
        out_int   = 1'b0;
        q_count   = r_q_count;
        if (w_valid) begin
            out_instr = w_head;
            out_imm   = w_itype ? w_next : '0;
            out_pc    = w_head_addr + (w_itype ? c_PC_TWO : c_PC_ONE);
            out_int   = r_int_pending;
        end
    end

    // Control state: PC, epoch, interrupt flag, pointers and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= c_RESET_VEC;
            r_epoch       <= 1'b0;
            r_int_pending <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_q_count     <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
            r_inflight    <= '0;
        end else begin
            // In-flight tracking continues across redirects so stale
            // responses can still be matched and dropped
            if (w_issue) begin
                r_tag_wr <= r_tag_wr + c_PTR_ONE;
            end
            if (w_resp) begin
                r_tag_rd <= r_tag_rd + c_PTR_ONE;
            end
            r_inflight <= r_inflight + c_CNT_W'(w_issue) - c_CNT_W'(w_resp);

            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_epoch    <= ~r_epoch;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_q_count  <= '0;
                if (w_set_int) begin
                    r_int_pending <= 1'b1;
                end
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + c_PC_ONE;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                r_rd_ptr  <= r_rd_ptr + w_pop_ptr;
                r_q_count <= r_q_count + c_CNT_W'(w_push) - w_pop_cnt;
                if (w_pop) begin
                    r_int_pending <= 1'b0;
                end
            end
        end
    end

    // Storage arrays: contents are only meaningful under the counters,
    // so they carry no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_addr[r_wr_ptr]  <= w_resp_addr;
        end
        if (w_issue) begin
            r_tag_addr[r_tag_wr]  <= r_fetch_pc;
            r_tag_epoch[r_tag_wr] <= r_epoch;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Brief    : Directed self-checking bench for fetch_queue_unit with an
//            instruction-memory model of selectable 1- or 2-cycle latency
//            and a monitor that logs every accepted packet.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    logic        clk;
    logic        reset;
    logic        exception;
    logic        interrupt;
    logic        pop_pc;
    logic [31:0] pop_value;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_rvalid;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic [31:0] out_pc;
    logic        out_int;
    logic [2:0]  q_count;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_queue_unit dut (
        .clk        (clk),
        .reset      (reset),
        .exception  (exception),
        .interrupt  (interrupt),
        .pop_pc     (pop_pc),
        .pop_value  (pop_value),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_rvalid(imem_rvalid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_imm    (out_imm),
        .out_pc     (out_pc),
        .out_int    (out_int),
        .q_count    (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: a few fixed words, everything else 0x5 + low address bits
    function automatic logic [15:0] mem_val(input logic [31:0] a);
        case (a)
            32'd32:  return 16'h1000;
            32'd33:  return 16'h2000;
            32'd34:  return 16'h3000;
            32'd40:  return 16'h8123;
            32'd41:  return 16'hBEEF;
            default: return {4'h5, a[11:0]};
        endcase
    endfunction

    // Memory model: two-stage request pipeline, latency picked by mem_lat
    int          mem_lat;
    logic        v1, v2;
    logic [31:0] a1, a2;
    initial begin
        v1 = 1'b0; v2 = 1'b0; a1 = '0; a2 = '0;
    end
    always @(posedge clk) begin
        v1 <= imem_req;
        a1 <= imem_addr;
        v2 <= v1;
        a2 <= a1;
    end
    assign imem_rvalid = (mem_lat == 2) ? v2 : v1;
    assign imem_rdata  = mem_val((mem_lat == 2) ? a2 : a1);

    // Packet log, sampled one time unit before each rising edge
    logic [15:0] rec_instr [$];
    logic [15:0] rec_imm   [$];
    logic [31:0] rec_pc    [$];
    logic        rec_int   [$];
    always begin
        @(negedge clk);
        #4;
        if (!reset && out_valid && out_ready &&
            !(exception || interrupt || pop_pc || jmp)) begin
            rec_instr.push_back(out_instr);
            rec_imm.push_back(out_imm);
            rec_pc.push_back(out_pc);
            rec_int.push_back(out_int);
        end
    end

    // Missing log entries read as an all-ones sentinel so they never match
    function automatic logic [63:0] get_instr(input int k);
        return (k < rec_instr.size()) ? 64'(rec_instr[k]) : '1;
    endfunction
    function automatic logic [63:0] get_imm(input int k);
        return (k < rec_imm.size()) ? 64'(rec_imm[k]) : '1;
    endfunction
    function automatic logic [63:0] get_pc(input int k);
        return (k < rec_pc.size()) ? 64'(rec_pc[k]) : '1;
    endfunction
    function automatic logic [63:0] get_int(input int k);
        return (k < rec_int.size()) ? 64'(rec_int[k]) : '1;
    endfunction

    task automatic rec_clear();
        rec_instr.delete();
        rec_imm.delete();
        rec_pc.delete();
        rec_int.delete();
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int beef_seen;
        reset      = 1'b1;
        exception  = 1'b0;
        interrupt  = 1'b0;
        pop_pc     = 1'b0;
        pop_value  = '0;
        jmp        = 1'b0;
        jmp_target = '0;
        out_ready  = 1'b1;
        mem_lat    = 1;

        // Reset state
        @(negedge clk); #1;
        check_eq("rst_imem_req",  64'(imem_req),  64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_q_count",   64'(q_count),   64'd0);
        check_eq("rst_out_instr", 64'(out_instr), 64'd0);
        check_eq("rst_out_imm",   64'(out_imm),   64'd0);
        check_eq("rst_out_pc",    64'(out_pc),    64'd0);
        check_eq("rst_out_int",   64'(out_int),   64'd0);

        // Sequential fetch from RESET_VEC
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("first_req",  64'(imem_req),  64'd1);
        check_eq("first_addr", 64'(imem_addr), 64'd32);
        cycles(8);
        check_eq("seq0_instr", get_instr(0), 64'h1000);
        check_eq("seq0_pc",    get_pc(0),    64'd33);
        check_eq("seq1_instr", get_instr(1), 64'h2000);
        check_eq("seq1_pc",    get_pc(1),    64'd34);
        check_eq("seq2_instr", get_instr(2), 64'h3000);
        check_eq("seq2_pc",    get_pc(2),    64'd35);
        check_eq("seq0_imm",   get_imm(0),   64'd0);

        // I-type packet at 40 with immediate at 41
        jmp        = 1'b1;
        jmp_target = 32'd40;
        rec_clear();
        #1;
        check_eq("jmp_cycle_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        jmp = 1'b0;
        cycles(8);
        check_eq("itype_instr", get_instr(0), 64'h8123);
        check_eq("itype_imm",   get_imm(0),   64'hBEEF);
        check_eq("itype_pc",    get_pc(0),    64'd42);
        check_eq("post_itype_instr", get_instr(1), 64'h502A);
        check_eq("post_itype_imm",   get_imm(1),   64'd0);
        check_eq("post_itype_pc",    get_pc(1),    64'd43);
        beef_seen = 0;
        foreach (rec_instr[i]) if (rec_instr[i] == 16'hBEEF) beef_seen++;
        check_eq("imm_not_decoded", 64'(beef_seen), 64'd0);

        // Stall: queue saturates, fetch stops, head held
        jmp        = 1'b1;
        jmp_target = 32'd50;
        out_ready  = 1'b0;
        @(negedge clk);
        jmp = 1'b0;
        cycles(3);
        check_eq("stall_early_instr", 64'(out_instr), 64'h5032);
        cycles(7);
        check_eq("stall_q_count", 64'(q_count),   64'd4);
        check_eq("stall_req",     64'(imem_req),  64'd0);
        check_eq("stall_instr",   64'(out_instr), 64'h5032);
        check_eq("stall_pc",      64'(out_pc),    64'd51);
        check_eq("stall_valid",   64'(out_valid), 64'd1);
        out_ready = 1'b1;
        rec_clear();
        cycles(8);
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("resume%0d_instr", k), get_instr(k), 64'h5032 + 64'(k));
        check_eq("resume0_pc", get_pc(0), 64'd51);

        // Jump with two requests in flight (two-cycle memory)
        out_ready = 1'b0;
        cycles(8);
        mem_lat   = 2;
        out_ready = 1'b1;
        cycles(5);
        jmp        = 1'b1;
        jmp_target = 32'd100;
        rec_clear();
        #1;
        check_eq("jmp2_cycle_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        jmp = 1'b0;
        cycles(12);
        check_eq("jmp2_0_instr", get_instr(0), 64'h5064);
        check_eq("jmp2_0_pc",    get_pc(0),    64'd101);
        check_eq("jmp2_1_instr", get_instr(1), 64'h5065);
        check_eq("jmp2_1_pc",    get_pc(1),    64'd102);

        // pop_pc outranks jmp
        pop_pc     = 1'b1;
        pop_value  = 32'd60;
        jmp        = 1'b1;
        jmp_target = 32'd100;
        rec_clear();
        @(negedge clk);
        pop_pc = 1'b0;
        jmp    = 1'b0;
        cycles(12);
        check_eq("pop_instr", get_instr(0), 64'h503C);
        check_eq("pop_pc",    get_pc(0),    64'd61);

        // Exception with interrupt: exception wins, no interrupt marking
        exception = 1'b1;
        interrupt = 1'b1;
        rec_clear();
        @(negedge clk);
        exception = 1'b0;
        interrupt = 1'b0;
        cycles(12);
        check_eq("exc_instr", get_instr(0), 64'h1000);
        check_eq("exc_pc",    get_pc(0),    64'd33);
        check_eq("exc_int",   get_int(0),   64'd0);
        check_eq("exc1_int",  get_int(1),   64'd0);

        // Interrupt alone: first packet marked, following one not
        interrupt = 1'b1;
        rec_clear();
        @(negedge clk);
        interrupt = 1'b0;
        cycles(12);
        check_eq("int0_instr", get_instr(0), 64'h5000);
        check_eq("int0_pc",    get_pc(0),    64'd1);
        check_eq("int0_int",   get_int(0),   64'd1);
        check_eq("int1_instr", get_instr(1), 64'h5001);
        check_eq("int1_int",   get_int(1),   64'd0);

        // Asynchronous reset mid-fetch
        check_eq("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_out_instr", 64'(out_instr), 64'd0);
        check_eq("arst_out_pc",    64'(out_pc),    64'd0);
        check_eq("arst_q_count",   64'(q_count),   64'd0);
        check_eq("arst_imem_req",  64'(imem_req),  64'd0);
        check_eq("arst_out_int",   64'(out_int),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        rec_clear();
        cycles(12);
        check_eq("post_rst_instr", get_instr(0), 64'h1000);
        check_eq("post_rst_pc",    get_pc(0),    64'd33);
        check_eq("post_rst_int",   get_int(0),   64'd0);
        check_eq("post_rst1_instr", get_instr(1), 64'h2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
